mfp_uart_transmitter: RTL and testbench



---
 rtl/mfp_uart_transmitter_pkg.sv | 29 ++
 rtl/mfp_uart_tx_fifo.sv | 59 +++++
 rtl/mfp_uart_transmitter.sv | 176 +++++++++++++++++
 tb/tb_mfp_uart_transmitter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mfp_uart_transmitter_pkg.sv
// Shared configuration for the MFP UART transmitter: default baud rate and FSM state encodings.
// Defining MFP_UART_TX_PARITY_EN widens the state encoding to make room for the PARITY state.
package mfp_uart_transmitter_pkg;

  localparam int MFP_UART_BAUD_RATE = 115200;

`ifdef MFP_UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;
`endif

  // Clocks per serial bit, rounded to the nearest integer.
  function automatic int baud_divisor(input int clk_freq, input int baud_rate);
    return (clk_freq + baud_rate / 2) / baud_rate;
  endfunction

endpackage

// File: rtl/mfp_uart_tx_fifo.sv
// Parameterised synchronous FIFO buffering CPU writes ahead of the UART shifter.
// Full/empty are decoded from a registered occupancy count; pointers wrap modulo depth.
module mfp_uart_tx_fifo #(
  parameter int ADDR_W = 3,
  parameter int WIDTH  = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (ADDR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // A simultaneous push and pop leaves the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mfp_uart_transmitter.sv
// Byte-serial UART transmitter (8N1, LSB first) fed from a small write FIFO.
// Defining MFP_UART_TX_PARITY_EN inserts a parity bit (even by default, odd with PARITY_ODD=1).
module mfp_uart_transmitter
  import mfp_uart_transmitter_pkg::*;
#(
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD_RATE   = MFP_UART_BAUD_RATE,
  parameter int FIFO_ADDR_W = 3
`ifdef MFP_UART_TX_PARITY_EN
  ,
  parameter bit PARITY_ODD  = 1'b0
`endif
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       overflow,
  output logic       tx
);

  localparam int DIV   = baud_divisor(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DIV - 1);

  generate
    if (DIV < 2) begin : g_div_check
      $error("mfp_uart_transmitter: baud divisor %0d is below 2", DIV);
    end
  endgenerate

  tx_state_t  state;
  tx_state_t  state_next;
  logic [CNT_W-1:0] baud_cnt;
  logic [CNT_W-1:0] baud_cnt_next;
  logic [2:0] bit_idx;
  logic [2:0] bit_idx_next;
  logic [7:0] shift;
  logic [7:0] shift_next;
  logic [7:0] head;
  logic       pop;
  logic       tx_next;
  logic       cnt_zero;
`ifdef MFP_UART_TX_PARITY_EN
  logic       parity_bit;
  logic       parity_next;
`endif

  mfp_uart_tx_fifo #(
    .ADDR_W (FIFO_ADDR_W),
    .WIDTH  (8)
  ) u_fifo (
    .clock   (clock),
    .resetn  (resetn),
    .push    (wr_en),
    .pop     (pop),
    .wr_data (wr_data),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  assign busy     = (state != IDLE);
  assign cnt_zero = (baud_cnt == '0);

  always_comb begin
    state_next    = state;
    baud_cnt_next = baud_cnt;
    bit_idx_next  = bit_idx;
    shift_next    = shift;
    pop           = 1'b0;
    tx_next       = 1'b1;
`ifdef MFP_UART_TX_PARITY_EN
    parity_next   = parity_bit;
`endif

    case (state)
      IDLE: begin
        if (!empty) begin
          pop           = 1'b1;
          shift_next    = head;
          baud_cnt_next = CNT_RELOAD;
          state_next    = START;
`ifdef MFP_UART_TX_PARITY_EN
          parity_next   = (^head) ^ PARITY_ODD;
`endif
        end
      end
      START: begin
        if (cnt_zero) begin
          baud_cnt_next = CNT_RELOAD;
          bit_idx_next  = 3'd0;
          state_next    = DATA;
        end else begin
          baud_cnt_next = baud_cnt - 1'b1;
        end
      end
      DATA: begin
        if (cnt_zero) begin
          baud_cnt_next = CNT_RELOAD;
          shift_next    = {1'b0, shift[7:1]};
          bit_idx_next  = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef MFP_UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end else begin
          baud_cnt_next = baud_cnt - 1'b1;
        end
      end
`ifdef MFP_UART_TX_PARITY_EN
      PARITY: begin
        if (cnt_zero) begin
          baud_cnt_next = CNT_RELOAD;
          state_next    = STOP;
        end else begin
          baud_cnt_next = baud_cnt - 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt_zero) begin
          state_next = IDLE;
        end else begin
          baud_cnt_next = baud_cnt - 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // The line level is decided from the upcoming state so tx can be a plain register.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
`ifdef MFP_UART_TX_PARITY_EN
      PARITY:  tx_next = parity_next;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shift    <= 8'd0;
      tx       <= 1'b1;
      overflow <= 1'b0;
`ifdef MFP_UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      baud_cnt <= baud_cnt_next;
      bit_idx  <= bit_idx_next;
      shift    <= shift_next;
      tx       <= tx_next;
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
`ifdef MFP_UART_TX_PARITY_EN
      parity_bit <= parity_next;
`endif
    end
  end

endmodule

// File: tb/tb_mfp_uart_transmitter.sv
// Self-checking bench for mfp_uart_transmitter: a fast DIV=16 / depth-4 instance and a default-rate instance.
// Expected frames are hand-written {stop, data, start} vectors; MFP_UART_TX_PARITY_EN adds parity expectations.
module tb_mfp_uart_transmitter;

  localparam int DIV  = 16;
  localparam int DIV2 = 434;
`ifdef MFP_UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_LEN = FRAME_BITS * DIV;
  localparam int HIST_LEN  = FRAME_LEN + 40;

  typedef struct {
    logic [7:0] data;
    logic [9:0] exp_frame;
    logic       exp_par;
  } frame_vec_t;

  logic       clock;
  logic       resetn;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full, empty, busy, overflow, tx;
  logic       wr_en2;
  logic [7:0] wr_data2;
  logic       full2, empty2, busy2, overflow2, tx2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mfp_uart_transmitter #(
    .CLK_FREQ    (16),
    .BAUD_RATE   (1),
    .FIFO_ADDR_W (2)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .busy     (busy),
    .overflow (overflow),
    .tx       (tx)
  );

  mfp_uart_transmitter dut_rate (
    .clock    (clock),
    .resetn   (resetn),
    .wr_en    (wr_en2),
    .wr_data  (wr_data2),
    .full     (full2),
    .empty    (empty2),
    .busy     (busy2),
    .overflow (overflow2),
    .tx       (tx2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  // Single-cycle write pulse; called and returns on a falling edge.
  task automatic apply_stimulus(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clock);
    wr_en   = 1'b0;
  endtask

  task automatic capture_frame(output logic [FRAME_BITS-1:0] bits, output int fall_cyc);
    int waited = 0;
    bits = '1;
    while (tx !== 1'b0 && waited < 4 * FRAME_LEN) begin
      @(negedge clock);
      waited++;
    end
    check_output("frame_start_seen", tx, 1'b0);
    fall_cyc = cyc;
    repeat (DIV / 2) @(negedge clock);
    bits[0] = tx;
    for (int k = 1; k < FRAME_BITS; k++) begin
      repeat (DIV) @(negedge clock);
      bits[k] = tx;
    end
  endtask

  task automatic check_frame(input string name, input frame_vec_t v, input logic [FRAME_BITS-1:0] cap);
`ifdef MFP_UART_TX_PARITY_EN
    check_output(name, {cap[10], cap[8:0]}, v.exp_frame);
    check_output({name, "_parity"}, cap[9], v.exp_par);
`else
    check_output(name, cap, v.exp_frame);
`endif
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy !== 1'b0 || empty !== 1'b1) && n < 8 * FRAME_LEN) begin
      @(negedge clock);
      n++;
    end
    check_output("idle_reached", {busy, empty}, 2'b01);
    @(negedge clock);
  endtask

  frame_vec_t table_vec [5];
  frame_vec_t burst_vec [3];
  frame_vec_t ovf_vec [6];
  frame_vec_t vec_55, vec_96;
  logic [FRAME_BITS-1:0] cap;
  logic tx_hist [HIST_LEN];
  logic busy_hist [HIST_LEN];
  logic empty_hist [HIST_LEN];
  int f_cyc, f2_cyc, f3_cyc, n0, busy_cnt, low_cnt, n, f_edge, r_edge, b_edge;

  initial begin
    table_vec[0] = '{8'h3C, 10'b1001111000, 1'b0};
    table_vec[1] = '{8'h81, 10'b1100000010, 1'b0};
    table_vec[2] = '{8'h07, 10'b1000001110, 1'b1};
    table_vec[3] = '{8'h03, 10'b1000000110, 1'b0};
    table_vec[4] = '{8'hC8, 10'b1110010000, 1'b1};
    burst_vec[0] = '{8'h00, 10'b1000000000, 1'b0};
    burst_vec[1] = '{8'hFF, 10'b1111111110, 1'b0};
    burst_vec[2] = '{8'hA5, 10'b1101001010, 1'b0};
    ovf_vec[0]   = '{8'h21, 10'b1001000010, 1'b0};
    ovf_vec[1]   = '{8'h32, 10'b1001100100, 1'b1};
    ovf_vec[2]   = '{8'h43, 10'b1010000110, 1'b1};
    ovf_vec[3]   = '{8'h54, 10'b1010101000, 1'b1};
    ovf_vec[4]   = '{8'h65, 10'b1011001010, 1'b0};
    ovf_vec[5]   = '{8'h76, 10'b1011101100, 1'b1};
    vec_55       = '{8'h55, 10'b1010101010, 1'b0};
    vec_96       = '{8'h96, 10'b1100101100, 1'b0};

    resetn = 1'b0; wr_en = 1'b0; wr_data = 8'h00; wr_en2 = 1'b0; wr_data2 = 8'h00;
    repeat (2) @(negedge clock);
    check_output("reset_tx", tx, 1'b1);
    check_output("reset_busy", busy, 1'b0);
    check_output("reset_full", full, 1'b0);
    check_output("reset_empty", empty, 1'b1);
    check_output("reset_overflow", overflow, 1'b0);
    resetn = 1'b1;
    @(negedge clock);

    $display("[TB] basic frame 0x55");
    apply_stimulus(8'h55);
    for (int i = 0; i < HIST_LEN; i++) begin
      if (i > 0) @(negedge clock);
      tx_hist[i]    = tx;
      busy_hist[i]  = busy;
      empty_hist[i] = empty;
    end
    check_output("basic_tx_after_write_edge", tx_hist[0], 1'b1);
    check_output("basic_empty_after_write_edge", empty_hist[0], 1'b0);
    check_output("basic_tx_falls_next_edge", tx_hist[1], 1'b0);
    check_output("basic_empty_after_pop", empty_hist[1], 1'b1);
    busy_cnt = 0;
    for (int i = 0; i < HIST_LEN; i++) busy_cnt += busy_hist[i] ? 1 : 0;
    check_output("basic_busy_clocks", busy_cnt, FRAME_LEN);
    check_output("basic_busy_drops", {busy_hist[FRAME_LEN], busy_hist[FRAME_LEN + 1]}, 2'b10);
    for (int k = 0; k < FRAME_BITS; k++) cap[k] = tx_hist[1 + DIV / 2 + k * DIV];
    check_frame("basic_frame", vec_55, cap);

    $display("[TB] table vectors");
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(table_vec[i].data);
      capture_frame(cap, f_cyc);
      check_frame($sformatf("table_frame_%0d", i), table_vec[i], cap);
    end
    wait_idle();

    $display("[TB] burst of three bytes");
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = burst_vec[i].data;
      @(negedge clock);
      if (i == 0) n0 = cyc;
    end
    wr_en = 1'b0;
    capture_frame(cap, f_cyc);
    check_frame("burst_frame_0", burst_vec[0], cap);
    capture_frame(cap, f2_cyc);
    check_frame("burst_frame_1", burst_vec[1], cap);
    check_output("burst_start_1", f2_cyc, n0 + 1 + FRAME_LEN + 1);
    capture_frame(cap, f3_cyc);
    check_frame("burst_frame_2", burst_vec[2], cap);
    check_output("burst_start_2", f3_cyc, n0 + 1 + 2 * (FRAME_LEN + 1));
    wait_idle();

    $display("[TB] overflow with depth 4");
    apply_stimulus(8'h11);
    @(negedge clock);
    check_output("ovf_fsm_busy", busy, 1'b1);
    wr_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_data = ovf_vec[i].data;
      @(negedge clock);
      if (i == 3) begin
        check_output("ovf_full_after_4", full, 1'b1);
        check_output("ovf_clear_after_4", overflow, 1'b0);
      end
    end
    check_output("ovf_set_after_6", overflow, 1'b1);
    check_output("ovf_still_full", full, 1'b1);
    wr_data = 8'hEE;
    n = 0;
    while (busy === 1'b1 && n < 2 * FRAME_LEN) begin
      @(negedge clock);
      n++;
    end
    check_output("ovf_idle_gap_seen", busy, 1'b0);
    @(negedge clock);
    wr_en = 1'b0;
    check_output("ovf_write_dropped_on_pop", full, 1'b0);
    check_output("ovf_sticky", overflow, 1'b1);
    for (int i = 0; i < 4; i++) begin
      capture_frame(cap, f_cyc);
      check_frame($sformatf("ovf_frame_%0d", i), ovf_vec[i], cap);
    end
    low_cnt = 0;
    repeat (2 * FRAME_LEN) begin
      @(negedge clock);
      low_cnt += (tx === 1'b0) ? 1 : 0;
    end
    check_output("ovf_no_dropped_frames", low_cnt, 0);
    check_output("ovf_empty_after", empty, 1'b1);

    $display("[TB] reset mid-frame");
    apply_stimulus(8'hF0);
    n = 0;
    while (tx !== 1'b0 && n < 4 * FRAME_LEN) begin
      @(negedge clock);
      n++;
    end
    repeat (DIV / 2 + 4 * DIV) @(negedge clock);
    check_output("rst_pre_data_bit3", tx, 1'b0);
    #2 resetn = 1'b0;
    #1;
    check_output("rst_async_tx", tx, 1'b1);
    check_output("rst_async_busy", busy, 1'b0);
    check_output("rst_async_empty", empty, 1'b1);
    check_output("rst_async_full", full, 1'b0);
    check_output("rst_async_overflow", overflow, 1'b0);
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    apply_stimulus(8'h96);
    capture_frame(cap, f_cyc);
    check_frame("rst_fresh_frame", vec_96, cap);
    wait_idle();

    $display("[TB] default divisor rounding");
    wr_en2   = 1'b1;
    wr_data2 = 8'h55;
    @(negedge clock);
    wr_en2   = 1'b0;
    n = 0;
    while (tx2 !== 1'b0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    f_edge = cyc;
    n = 0;
    while (tx2 !== 1'b1 && n < 2 * DIV2) begin
      @(negedge clock);
      n++;
    end
    r_edge = cyc;
    check_output("rate_bit_clocks", r_edge - f_edge, DIV2);
    n = 0;
    while (busy2 !== 1'b0 && n < 2 * FRAME_BITS * DIV2) begin
      @(negedge clock);
      n++;
    end
    b_edge = cyc;
    check_output("rate_frame_clocks", b_edge - f_edge, FRAME_BITS * DIV2);
    check_output("rate_flags", {empty2, full2, overflow2}, 3'b100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
